// File: rtl/accel_avg_filter.sv
// accel_avg_filter: sequential moving-average filter for one accelerometer axis, 32-bit sign-extended output.
// Define ACCEL_AVG_FILT_ROUND_EN to round half toward +inf instead of truncating toward -inf.
module accel_avg_filter #(
    parameter int SAMPLE_W  = 16,
    parameter int LOG2_TAPS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                flush,
    input  logic                clr_overrun,
    output logic [31:0]         filt_out,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun
);
    localparam int TAPS = 2 ** LOG2_TAPS;
    localparam int AW   = SAMPLE_W + LOG2_TAPS;
    localparam int IW   = (LOG2_TAPS > 0) ? LOG2_TAPS : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                     state, state_next;
    logic signed [SAMPLE_W-1:0] taps [TAPS];
    logic signed [SAMPLE_W-1:0] pend, accept_val;
    logic                       pend_full, accept, ovr_set;
    logic signed [AW-1:0]       acc;
    logic signed [AW:0]         sum_w, shifted;
    logic [IW-1:0]              idx;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        accept_val = pend_full ? pend : $signed(sample_in);
        if (flush)
            state_next = IDLE;
        else
            case (state)
                IDLE: begin
                    accept     = pend_full | sample_valid;
                    state_next = accept ? ACCUM : IDLE;
                end
                ACCUM:   state_next = (idx == IW'(TAPS - 1)) ? DONE : ACCUM;
                default: state_next = IDLE;
            endcase
        ovr_set = !flush && state != IDLE && sample_valid && pend_full;
`ifdef ACCEL_AVG_FILT_ROUND_EN
        sum_w = {acc[AW-1], acc} + (AW + 1)'((2 ** LOG2_TAPS) / 2);
`else
        sum_w = {acc[AW-1], acc};
`endif
        shifted = sum_w >>> LOG2_TAPS;
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) taps[i] <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            filt_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= !flush && state == DONE;
            if (!flush && state == DONE) filt_out <= {{(31 - AW){shifted[AW]}}, shifted};
            overrun <= ovr_set | (overrun & ~clr_overrun);
            if (flush) begin
                for (int i = 0; i < TAPS; i++) taps[i] <= '0;
                pend_full <= 1'b0;
                acc       <= '0;
                idx       <= '0;
            end else begin
                if (accept) begin
                    taps[0] <= accept_val;
                    for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
                    acc <= '0;
                    idx <= '0;
                end else if (state == ACCUM) begin
                    acc <= acc + AW'(taps[idx]);
                    idx <= idx + 1'b1;
                end
                // In IDLE a full pending slot drains unless a same-cycle sample refills it
                if (state == IDLE) pend_full <= pend_full & sample_valid;
                else if (sample_valid) pend_full <= 1'b1;
                if (sample_valid && (state != IDLE || pend_full)) pend <= sample_in;
            end
        end
    end
endmodule

// File: tb/tb_accel_avg_filter.sv
// tb_accel_avg_filter: directed test-plan scenarios plus random traffic checked against a behavioural model.
module tb_accel_avg_filter;
    localparam int SAMPLE_W  = 16;
    localparam int LOG2_TAPS = 2;
    localparam int TAPS      = 2 ** LOG2_TAPS;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [SAMPLE_W-1:0] sample_in = '0;
    logic                sample_valid = 1'b0, flush = 1'b0, clr_overrun = 1'b0;
    logic [31:0]         filt_out;
    logic                out_valid, busy, overrun;

    accel_avg_filter #(.SAMPLE_W(SAMPLE_W), .LOG2_TAPS(LOG2_TAPS)) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .flush(flush), .clr_overrun(clr_overrun), .filt_out(filt_out), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the last TAPS accepted samples, a one-deep pending slot and a
    // countdown of TAPS+1 edges from acceptance to the published average.
    int          hist [TAPS];
    bit          m_pend_full = 0, m_valid = 0, m_ovr = 0;
    int          m_pend = 0, m_cnt = 0, m_res = 0;
    logic [31:0] m_filt = '0;

    function automatic int avg_of();
        int s = 0, q;
        for (int i = 0; i < TAPS; i++) s += hist[i];
`ifdef ACCEL_AVG_FILT_ROUND_EN
        s += TAPS / 2;
`endif
        q = s / TAPS;
        if (s % TAPS != 0 && s < 0) q--;
        return q;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) hist[i] = 0;
            m_pend_full = 0; m_pend = 0; m_cnt = 0; m_res = 0;
            m_filt = '0; m_valid = 0; m_ovr = 0;
        end else begin
            bit set;
            int v, sin;
            set = 0;
            sin = $signed(sample_in);
            m_valid = 0;
            if (flush) begin
                for (int i = 0; i < TAPS; i++) hist[i] = 0;
                m_pend_full = 0;
                m_cnt = 0;
            end else if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin m_valid = 1; m_filt = m_res; end
                if (sample_valid) begin set = m_pend_full; m_pend = sin; m_pend_full = 1; end
            end else if (m_pend_full || sample_valid) begin
                v = m_pend_full ? m_pend : sin;
                if (m_pend_full) begin m_pend_full = sample_valid; m_pend = sin; end
                for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = v;
                m_res = avg_of();
                m_cnt = TAPS + 1;
            end
            m_ovr = set | (m_ovr & !clr_overrun);
        end
    end

    always @(negedge clk)
        if (reset_n && chk_en) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("filt_out", filt_out, m_filt);
            check("busy", 32'(busy), 32'(m_cnt != 0));
            check("overrun", 32'(overrun), 32'(m_ovr));
        end

    task automatic send(input int v, output logic [31:0] res);
        int k = 0;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = SAMPLE_W'(v);
        @(negedge clk);
        sample_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'd6);
        res = filt_out;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic zero_outputs(input string tag);
        check({tag, "_filt"}, filt_out, 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        logic [31:0] r, held;
        int n;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        zero_outputs("rst");
        reset_n = 1'b1;
        chk_en  = 1'b1;

        for (int k = 1; k <= 4; k++) begin
            send(100, r);
            check("ramp", r, 32'(25 * k));
        end

        pulse_flush();
        send(-8, r);
        check("neg_first", r, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) send(-8, r);
        check("neg_last", r, 32'hFFFF_FFF8);

        pulse_flush();
        send(2, r);
`ifdef ACCEL_AVG_FILT_ROUND_EN
        check("round_pos", r, 32'd1);
`else
        check("round_pos", r, 32'd0);
`endif
        for (int k = 0; k < 3; k++) send(0, r);
        pulse_flush();
        send(-1, r);
`ifdef ACCEL_AVG_FILT_ROUND_EN
        check("round_neg", r, 32'd0);
`else
        check("round_neg", r, 32'hFFFF_FFFF);
`endif

        pulse_flush();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in    = SAMPLE_W'(10 * k);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            if (out_valid) n++;
            if (n < 2) @(negedge clk);
        end
        check("ovr_results", 32'(n), 32'd2);
        check("ovr_second", filt_out, 32'd10);
        check("ovr_set", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        held = filt_out;
        pulse_flush();
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = SAMPLE_W'(7);
        @(negedge clk);
        sample_in    = SAMPLE_W'(9);
        @(negedge clk);
        sample_valid = 1'b0;
        flush        = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("flush_no_out", 32'(n), 32'd0);
        check("flush_hold", filt_out, held);
        send(40, r);
        check("after_flush", r, 32'd10);

        pulse_flush();
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = SAMPLE_W'(8);
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 zero_outputs("areset");
        @(negedge clk);
        reset_n = 1'b1;
        send(4, r);
        check("post_reset", r, 32'd1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sample_valid = ($urandom_range(99) < 30);
            sample_in    = SAMPLE_W'($urandom);
            flush        = ($urandom_range(99) < 2);
            clr_overrun  = ($urandom_range(99) < 5);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        flush        = 1'b0;
        clr_overrun  = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
